// File: rtl/ram_loader.sv
// ram_loader: streams in_data words into a 2^ADDR_W x DATA_W RAM from base_addr, with a registered read port.
// Optional running checksum of accepted words is enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_a_n,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] checksum
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_start;
    logic [ADDR_W:0]   w_count_nxt;

    assign in_ready    = (r_state == S_LOAD) && !abort;
    assign w_accept    = in_ready && in_valid;
    assign w_start     = (r_state == S_IDLE) && start_load && (length != '0);
    assign w_count_nxt = r_count + (ADDR_W+1)'(1);

    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_count;
    assign rd_data  = r_rd_data;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_load) begin
                        r_count <= '0;
                        if (length != '0) begin
                            r_addr  <= base_addr;
                            r_len   <= length;
                            r_busy  <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        // address wraps naturally at 2^ADDR_W
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= w_count_nxt;
                        if (w_count_nxt == r_len) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM array is deliberately outside reset so contents survive rst_a_n
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_ram_loader;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_a_n = 1'b1;
    logic          start_load = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          abort = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [DW-1:0] checksum;

    ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_a_n(rst_a_n), .start_load(start_load), .base_addr(base_addr),
        .length(length), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .wr_count(wr_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int done_seen = 0;
    int busy_seen = 0;

    // Transaction-level model: a load is "active" with a pointer and words remaining.
    logic [DW-1:0] m_mem [0:255];
    bit            m_known [0:255];
    logic [DW-1:0] fill_data [0:255];
    bit            m_active;
    bit            m_done;
    int            m_count;
    int            m_left;
    int            m_sum;
    int            m_ptr;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            m_active = 0; m_done = 0; m_count = 0; m_left = 0;
            m_sum = 0; m_ptr = 0; m_rd = '0; m_rd_known = 1;
        end else begin
            m_rd = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            m_done = 0;
            if (!m_active) begin
                if (start_load) begin
                    m_count = 0;
                    if (length == 0) begin
                        m_done = 1;
                    end else begin
                        m_active = 1; m_ptr = int'(base_addr); m_left = int'(length); m_sum = 0;
                    end
                end
            end else if (abort) begin
                m_active = 0;
            end else if (in_valid) begin
                m_mem[m_ptr] = in_data;
                m_known[m_ptr] = 1;
                m_ptr = (m_ptr + 1) % 256;
                m_count = m_count + 1;
                m_sum = (m_sum + int'(in_data)) % 256;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum();
`ifdef RAM_LOADER_CHECKSUM_EN
        return 32'(m_sum);
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_a_n) begin
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(m_active && !abort));
            chk("wr_count", 32'(wr_count), 32'(m_count));
            chk("checksum", 32'(checksum), exp_sum());
            if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [AW:0] l);
        start_load = 1'b1; base_addr = b; length = l;
        step();
        start_load = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 600) begin
            step();
            k++;
        end
        chk({name, "_timeout"}, 32'(k < 600), 32'd1);
        step();
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        @(negedge clk);
        chk(name, 32'(rd_data), 32'(exp));
        #1;
    endtask

    initial begin
        #1 rst_a_n = 1'b0;
        #20;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_count", 32'(wr_count), 0);
        chk("rst_rd", 32'(rd_data), 0);
        chk("rst_sum", 32'(checksum), 0);
        @(negedge clk);
        #1 rst_a_n = 1'b1;
        step();

        // Full-depth load writes every location once, starting mid-array to exercise wrap
        for (int i = 0; i < 256; i++) fill_data[i] = DW'($urandom);
        done_seen = 0;
        start(8'h80, 9'h100);
        for (int i = 0; i < 256; i++) send(fill_data[(i + 128) % 256]);
        wait_idle("fill");
        chk("fill_done", 32'(done_seen), 1);
        chk("fill_count", 32'(wr_count), 32'h100);
        read_chk("fill_rd7F", 8'h7F, fill_data[8'h7F]);
        read_chk("fill_rd80", 8'h80, fill_data[8'h80]);

        // Basic back-to-back load
        done_seen = 0;
        start(8'h10, 9'd4);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        wait_idle("load");
        chk("load_done", 32'(done_seen), 1);
        chk("load_busy", 32'(busy), 0);
        chk("load_count", 32'(wr_count), 4);
`ifdef RAM_LOADER_CHECKSUM_EN
        // 0xA1+0xB2+0xC3+0xD4 = 0x2EA, mod 256
        chk("load_sum", 32'(checksum), 32'hEA);
`else
        chk("load_sum", 32'(checksum), 0);
`endif
        read_chk("load_rd10", 8'h10, 8'hA1);
        read_chk("load_rd11", 8'h11, 8'hB2);
        read_chk("load_rd12", 8'h12, 8'hC3);
        read_chk("load_rd13", 8'h13, 8'hD4);

        // Address wrap
        done_seen = 0;
        start(8'hFE, 9'd3);
        send(8'h11); send(8'h22); send(8'h33);
        wait_idle("wrap");
        chk("wrap_done", 32'(done_seen), 1);
        read_chk("wrap_rdFE", 8'hFE, 8'h11);
        read_chk("wrap_rdFF", 8'hFF, 8'h22);
        read_chk("wrap_rd00", 8'h00, 8'h33);

        // Stall with in_valid pattern 1,0,0,1,1
        done_seen = 0;
        start(8'h40, 9'd3);
        send(8'h5A); step(); step(); send(8'h6B); send(8'h7C);
        wait_idle("stall");
        chk("stall_done", 32'(done_seen), 1);
        chk("stall_count", 32'(wr_count), 3);
        read_chk("stall_rd40", 8'h40, 8'h5A);
        read_chk("stall_rd41", 8'h41, 8'h6B);
        read_chk("stall_rd42", 8'h42, 8'h7C);

        // Abort after two words; the word offered with abort must not land
        done_seen = 0;
        start(8'h80, 9'd8);
        send(8'hE1); send(8'hE2);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_count", 32'(wr_count), 2);
        step(); step();
        chk("abort_done", 32'(done_seen), 0);
        read_chk("abort_rd80", 8'h80, 8'hE1);
        read_chk("abort_rd81", 8'h81, 8'hE2);
        read_chk("abort_rd82", 8'h82, fill_data[8'h82]);

        // Zero length
        done_seen = 0; busy_seen = 0;
        start(8'h33, 9'd0);
        step(); step();
        chk("zero_done", 32'(done_seen), 1);
        chk("zero_busy", 32'(busy_seen), 0);
        chk("zero_count", 32'(wr_count), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start_load = ($urandom_range(0, 9) == 0);
            base_addr  = AW'($urandom);
            length     = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
            abort      = ($urandom_range(0, 24) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = DW'($urandom);
            rd_addr    = AW'($urandom);
            step();
        end
        start_load = 1'b0; in_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // Asynchronous reset in the middle of a load
        done_seen = 0;
        start(8'h20, 9'd10);
        send(8'h01); send(8'h02); send(8'h03);
        #2 rst_a_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_count", 32'(wr_count), 0);
        chk("mid_rst_sum", 32'(checksum), 0);
        chk("mid_rst_rd", 32'(rd_data), 0);
        @(negedge clk);
        #1 rst_a_n = 1'b1;
        step();
        chk("mid_rst_nodone", 32'(done_seen), 0);
        read_chk("mid_rst_rd20", 8'h20, 8'h01);
        read_chk("mid_rst_rd22", 8'h22, 8'h03);
        read_chk("mid_rst_rd23", 8'h23, m_mem[8'h23]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
